// File: rtl/led_feedback.sv
// -----------------------------------------------------------------------------
// led_feedback
//
// Mastermind feedback stage. A one-cycle LED_Proc strobe in IDLE latches the
// secret (codemaker_code) and the guess (codebreaker_code). The block then
// scores them:
//   exact   = right letter in the right slot
//   partial = right letter in the wrong slot, each letter counted at most once
// The result is held on the LEDs for DISPLAY_CYCLES cycles, and then done
// pulses for one cycle.
//
// Ports
//   clk               in   1   system clock, rising edge
//   reset             in   1   asynchronous active-low reset
//   LED_Proc          in   1   start strobe, sampled only in IDLE
//   codemaker_code    in  12   secret, 4 letters x 3 bits, letter 0 in [11:9]
//   codebreaker_code  in  12   guess, same layout
//   led_exact         out  4   per-slot exact mask, letter n -> bit 3-n
//   exact_count       out  3   number of exact matches (0..4)
//   partial_count     out  3   number of partial matches (0..4)
//   show_valid        out  1   high while the result is on display
//   busy              out  1   high in every state except IDLE
//   done              out  1   one-cycle pulse when the display time ends
// -----------------------------------------------------------------------------
module led_feedback #(
    parameter int DISPLAY_CYCLES = 50_000_000,
    parameter int TIMER_W        = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LED_Proc,
    input  logic [11:0] codemaker_code,
    input  logic [11:0] codebreaker_code,
    output logic [3:0]  led_exact,
    output logic [2:0]  exact_count,
    output logic [2:0]  partial_count,
    output logic        show_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXACT   = 3'd1,
        ST_PARTIAL = 3'd2,
        ST_SHOW    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;

    logic [11:0]         secret_r;
    logic [11:0]         guess_r;
    logic [3:0]          used_s_r;      // secret slots already consumed by a match
    logic [3:0]          used_g_r;      // guess slots already consumed by a match
    logic [3:0]          idx_r;         // EXACT: [1:0]=slot; PARTIAL: [3:2]=secret, [1:0]=guess
    logic [TIMER_W-1:0]  timer_r;

    logic [3:0]          led_exact_r;
    logic [2:0]          exact_count_r;
    logic [2:0]          partial_count_r;
    logic                show_valid_r;
    logic                busy_r;
    logic                done_r;

    logic [1:0]          slot_n_s;
    logic [1:0]          slot_i_s;
    logic [1:0]          slot_j_s;
    logic                exact_hit_s;
    logic                partial_hit_s;
    logic                timer_last_s;

    // Extract letter n (n=0 is the first entered letter, in the top bits).
    function automatic logic [2:0] letter_of(input logic [11:0] code, input logic [1:0] n);
        logic [2:0] l;
        l = 3'd0;
        case (n)
            2'd0:    l = code[11:9];
            2'd1:    l = code[8:6];
            2'd2:    l = code[5:3];
            2'd3:    l = code[2:0];
            default: l = 3'd0;
        endcase
        return l;
    endfunction

    assign slot_n_s = idx_r[1:0];
    assign slot_i_s = idx_r[3:2];
    assign slot_j_s = idx_r[1:0];

    // Match detection for the slot(s) addressed by the index this cycle.
    always_comb begin
        exact_hit_s   = 1'b0;
        partial_hit_s = 1'b0;
        timer_last_s  = 1'b0;
        exact_hit_s   = (letter_of(secret_r, slot_n_s) == letter_of(guess_r, slot_n_s));
        partial_hit_s = !used_s_r[slot_i_s] && !used_g_r[slot_j_s] &&
                        (letter_of(secret_r, slot_i_s) == letter_of(guess_r, slot_j_s));
        timer_last_s  = (timer_r == TIMER_W'(DISPLAY_CYCLES - 1));
    end

    // Next-state logic; an unknown encoding falls back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (LED_Proc) begin
                    state_next_s = ST_EXACT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXACT: begin
                if (idx_r[1:0] == 2'd3) begin
                    state_next_s = ST_PARTIAL;
                end else begin
                    state_next_s = ST_EXACT;
                end
            end
            ST_PARTIAL: begin
                // Always the full 16 pairs, independent of the data.
                if (idx_r == 4'd15) begin
                    state_next_s = ST_SHOW;
                end else begin
                    state_next_s = ST_PARTIAL;
                end
            end
            ST_SHOW: begin
                if (timer_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHOW;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus status flags registered from the next state, so
    // they line up exactly with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            show_valid_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            show_valid_r <= (state_next_s == ST_SHOW);
            done_r       <= (state_next_s == ST_DONE);
        end
    end

    // Scoring datapath: latches codes on start, walks the slots, runs the timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            secret_r        <= 12'd0;
            guess_r         <= 12'd0;
            used_s_r        <= 4'd0;
            used_g_r        <= 4'd0;
            idx_r           <= 4'd0;
            timer_r         <= {TIMER_W{1'b0}};
            led_exact_r     <= 4'd0;
            exact_count_r   <= 3'd0;
            partial_count_r <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (LED_Proc) begin
                        secret_r        <= codemaker_code;
                        guess_r         <= codebreaker_code;
                        used_s_r        <= 4'd0;
                        used_g_r        <= 4'd0;
                        idx_r           <= 4'd0;
                        timer_r         <= {TIMER_W{1'b0}};
                        led_exact_r     <= 4'd0;
                        exact_count_r   <= 3'd0;
                        partial_count_r <= 3'd0;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_EXACT: begin
                    if (exact_hit_s) begin
                        led_exact_r[2'd3 - slot_n_s] <= 1'b1;
                        used_s_r[slot_n_s]           <= 1'b1;
                        used_g_r[slot_n_s]           <= 1'b1;
                        exact_count_r                <= exact_count_r + 3'd1;
                    end else begin
                        exact_count_r <= exact_count_r;
                    end
                    // Restart the index at 0 so PARTIAL begins with pair (0,0).
                    if (slot_n_s == 2'd3) begin
                        idx_r <= 4'd0;
                    end else begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                ST_PARTIAL: begin
                    if (partial_hit_s) begin
                        partial_count_r    <= partial_count_r + 3'd1;
                        used_s_r[slot_i_s] <= 1'b1;
                        used_g_r[slot_j_s] <= 1'b1;
                    end else begin
                        partial_count_r <= partial_count_r;
                    end
                    // Wraps 15 -> 0 on the last pair.
                    idx_r <= idx_r + 4'd1;
                end
                ST_SHOW: begin
                    if (timer_last_s) begin
                        timer_r <= {TIMER_W{1'b0}};
                    end else begin
                        timer_r <= timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    timer_r <= {TIMER_W{1'b0}};
                end
                default: begin
                    timer_r <= {TIMER_W{1'b0}};
                end
            endcase
        end
    end

    assign led_exact     = led_exact_r;
    assign exact_count   = exact_count_r;
    assign partial_count = partial_count_r;
    assign show_valid    = show_valid_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_led_feedback.sv
// -----------------------------------------------------------------------------
// tb_led_feedback
//
// Directed bench for led_feedback with DISPLAY_CYCLES=8. A table of
// {secret, guess, expected exact, partial, led mask} records is run in a
// loop; hand-written sequences cover held start, extra start while busy,
// input changes after start and asynchronous reset mid-run.
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_led_feedback;

    localparam int D       = 8;
    localparam int LAT     = 21 + D;   // start edge -> cycle with done high

    logic        clk;
    logic        reset;
    logic        LED_Proc;
    logic [11:0] codemaker_code;
    logic [11:0] codebreaker_code;
    logic [3:0]  led_exact;
    logic [2:0]  exact_count;
    logic [2:0]  partial_count;
    logic        show_valid;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] secret;
        logic [11:0] guess;
        logic [2:0]  ex;
        logic [2:0]  pa;
        logic [3:0]  led;
    } vec_t;

    vec_t vecs[6];

    led_feedback #(.DISPLAY_CYCLES(D), .TIMER_W(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .LED_Proc         (LED_Proc),
        .codemaker_code   (codemaker_code),
        .codebreaker_code (codebreaker_code),
        .led_exact        (led_exact),
        .exact_count      (exact_count),
        .partial_count    (partial_count),
        .show_valid       (show_valid),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] code4(input int a, input int b, input int c, input int d);
        return {3'(a), 3'(b), 3'(c), 3'(d)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Start one run and follow it to done; optional extra strobe at cycle
    // pulse_at and optional scrambling of the input codes after the start edge.
    task automatic run_case(input vec_t v, input string name, input int pulse_at, input bit scramble);
        int lat;
        int shows;
        bit busy_ok;
        @(negedge clk);
        codemaker_code   = v.secret;
        codebreaker_code = v.guess;
        LED_Proc         = 1'b1;
        @(posedge clk);
        #1;
        LED_Proc = 1'b0;
        if (scramble) begin
            codemaker_code   = ~v.secret;
            codebreaker_code = 12'h000;
        end
        lat     = 0;
        shows   = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (show_valid) shows++;
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            LED_Proc = (c == pulse_at);
        end
        LED_Proc = 1'b0;
        check({name, " latency"},    32'(lat),           32'(LAT));
        check({name, " show_cyc"},   32'(shows),         32'(D));
        check({name, " busy_held"},  32'(busy_ok),       32'd1);
        check({name, " exact"},      32'(exact_count),   32'(v.ex));
        check({name, " partial"},    32'(partial_count), 32'(v.pa));
        check({name, " led_exact"},  32'(led_exact),     32'(v.led));
        @(negedge clk);
        check({name, " idle_busy"},  32'({busy, done, show_valid}), 32'd0);
        check({name, " hold_res"},   32'({led_exact, exact_count, partial_count}),
                                     32'({v.led, v.ex, v.pa}));
    endtask

    initial begin
        int dones;
        int lat2;

        vecs[0] = '{code4(1,2,3,4), code4(1,2,3,4), 3'd4, 3'd0, 4'b1111};
        vecs[1] = '{code4(1,2,3,4), code4(4,3,2,1), 3'd0, 3'd4, 4'b0000};
        vecs[2] = '{code4(1,1,2,2), code4(1,2,1,5), 3'd1, 3'd2, 4'b1000};
        vecs[3] = '{code4(7,7,7,7), code4(0,0,0,0), 3'd0, 3'd0, 4'b0000};
        vecs[4] = '{code4(1,2,3,4), code4(2,1,4,4), 3'd1, 3'd2, 4'b0001};
        vecs[5] = '{code4(0,1,2,3), code4(3,3,3,3), 3'd1, 3'd0, 4'b0001};

        reset            = 1'b0;
        LED_Proc         = 1'b0;
        codemaker_code   = 12'h000;
        codebreaker_code = 12'h000;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({led_exact, exact_count, partial_count, show_valid, busy, done}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven runs.
        for (int i = 0; i < 6; i++) begin
            run_case(vecs[i], $sformatf("vec%0d", i), 0, 1'b0);
        end

        // Held start: exactly one done, then a new run the cycle after DONE.
        @(negedge clk);
        codemaker_code   = vecs[3].secret;
        codebreaker_code = vecs[3].guess;
        LED_Proc         = 1'b1;
        @(posedge clk);
        dones = 0;
        lat2  = 0;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (c == LAT) check("hold done_at_lat", 32'(done), 32'd1);
            if (c == LAT + 1) check("hold idle_gap", 32'(busy), 32'd0);
            if (c == LAT + 2) check("hold restart", 32'(busy), 32'd1);
        end
        check("hold single_done", 32'(dones), 32'd1);
        LED_Proc = 1'b0;
        for (int c = LAT + 3; c <= 120; c++) begin
            @(negedge clk);
            if (done) begin
                lat2 = c;
                break;
            end
        end
        check("hold second_lat", 32'(lat2), 32'(2 * LAT + 1));
        check("hold second_res", 32'({led_exact, exact_count, partial_count}), 32'd0);
        @(negedge clk);

        // Extra strobe during PARTIAL plus scrambled inputs after start.
        run_case(vecs[0], "ignore_restart", 10, 1'b1);

        // Asynchronous reset in the 10th PARTIAL cycle (cycle 14 after start).
        @(negedge clk);
        codemaker_code   = vecs[2].secret;
        codebreaker_code = vecs[2].guess;
        LED_Proc         = 1'b1;
        @(posedge clk);
        #1;
        LED_Proc = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_reset busy", 32'({busy, exact_count}), 32'({1'b1, 3'd1}));
        #2;
        reset = 1'b0;
        #1;
        check("async_reset outputs", 32'({led_exact, exact_count, partial_count, show_valid, busy, done}), 32'd0);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (c == 3) reset = 1'b1;
        end
        check("async_reset no_done", 32'(dones), 32'd0);
        run_case(vecs[2], "after_reset", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
